// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read-channel arbiter.
// Round-robin AR arbitration with a grant lock that holds the slave-visible
// address stable until its handshake. An in-order ID FIFO records the owner
// of each accepted read, and R responses are steered back to that owner.
// The AR and R paths are purely combinational.
module axi_rd_arbiter #(
    parameter int MAX_OUTST  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // master 0 (fetch)
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [2:0]            m0_arprot,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    // master 1 (load/store)
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [2:0]            m1_arprot,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    // slave
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [2:0]            s_arprot,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

    logic                 lock;
    logic                 lock_id;
    logic                 rr_prio;
    logic [MAX_OUTST-1:0] fifo;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic grant;
    logic grant_vld;
    logic full;
    logic empty;
    logic head;
    logic ar_ok;
    logic push;
    logic pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = fifo[rd_ptr];

    // Grant selection: a locked grant wins, otherwise a lone requester, otherwise rr_prio.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (lock) begin
            grant     = lock_id;
            grant_vld = 1'b1;
        end else if (m0_arvalid && !m1_arvalid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (m1_arvalid && !m0_arvalid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end else if (m0_arvalid && m1_arvalid) begin
            grant     = rr_prio;
            grant_vld = 1'b1;
        end
    end

    // Reset gates the AR side so every output reads 0 while reset is held,
    // even if a master keeps arvalid asserted.
    assign ar_ok = grant_vld && !full && !reset;

    assign s_araddr   = grant ? m1_araddr : m0_araddr;
    assign s_arprot   = grant ? m1_arprot : m0_arprot;
    assign s_arvalid  = ar_ok && (grant ? m1_arvalid : m0_arvalid);
    assign m0_arready = ar_ok && !grant && s_arready;
    assign m1_arready = ar_ok &&  grant && s_arready;

    // R path: data/resp fan out to both; valid and ready follow the FIFO head.
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rvalid = !empty && !head && s_rvalid;
    assign m1_rvalid = !empty &&  head && s_rvalid;
    assign s_rready  = !empty && (head ? m1_rready : m0_rready);

    assign push = s_arvalid && s_arready;
    assign pop  = s_rvalid && s_rready;

    // Arbitration state: lock the grant while the slave stalls, rotate priority on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            rr_prio <= 1'b0;
        end else if (push) begin
            lock    <= 1'b0;
            rr_prio <= ~grant;
        end else if (s_arvalid) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    // In-order owner FIFO: push on AR handshake, pop on R handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= grant;
                wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (MAX_OUTST = 2). Inputs change 1 ns
// after the rising edge; combinational outputs are checked 1 ns later.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic [2:0]  m0_arprot, m1_arprot, s_arprot;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.MAX_OUTST(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_arvalid = 0; m1_arvalid = 0; s_arready = 0; s_rvalid = 0;
        m0_rready  = 0; m1_rready  = 0; s_rdata   = '0; s_rresp = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_arready"}, 32'(m0_arready), 0);
        chk({tag, "_m1_arready"}, 32'(m1_arready), 0);
        chk({tag, "_s_arvalid"},  32'(s_arvalid),  0);
        chk({tag, "_m0_rvalid"},  32'(m0_rvalid),  0);
        chk({tag, "_m1_rvalid"},  32'(m1_rvalid),  0);
        chk({tag, "_s_rready"},   32'(s_rready),   0);
        chk({tag, "_count"},      32'(dut.count),  0);
    endtask

    initial begin
        m0_araddr = '0; m1_araddr = '0; m0_arprot = 3'b100; m1_arprot = 3'b001;
        idle_inputs();
        reset = 1;
        #2;
        chk_all_zero("reset");
        do_reset();

        // ---- solo fetch: two back-to-back m0 reads, data after both accepted
        m0_arvalid = 1; m0_araddr = 32'h0; s_arready = 1; m0_rready = 1; m1_rready = 1;
        settle();
        chk("solo_arvalid",  32'(s_arvalid),  1);
        chk("solo_araddr0",  s_araddr,        32'h0);
        chk("solo_arprot",   32'(s_arprot),   32'h4);
        chk("solo_m0_ardy",  32'(m0_arready), 1);
        chk("solo_m1_ardy",  32'(m1_arready), 0);
        tick();
        m0_araddr = 32'h4;
        settle();
        chk("solo_araddr1",  s_araddr,        32'h4);
        chk("solo_m0_ardy1", 32'(m0_arready), 1);
        chk("solo_cnt1",     32'(dut.count),  1);
        tick();
        m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h11;
        settle();
        chk("solo_cnt_peak", 32'(dut.count),  2);
        chk("solo_rv0_a",    32'(m0_rvalid),  1);
        chk("solo_m1rv_a",   32'(m1_rvalid),  0);
        chk("solo_rdata_a",  m0_rdata,        32'h11);
        chk("solo_srdy_a",   32'(s_rready),   1);
        tick();
        s_rdata = 32'h22;
        settle();
        chk("solo_rv0_b",    32'(m0_rvalid),  1);
        chk("solo_m1rv_b",   32'(m1_rvalid),  0);
        chk("solo_rdata_b",  m0_rdata,        32'h22);
        tick();
        s_rvalid = 0;
        settle();
        chk("solo_cnt_end",  32'(dut.count),  0);

        // ---- contention: alternating grants from m0 after reset
        do_reset();
        m0_araddr = 32'h100; m1_araddr = 32'h200;
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; m0_rready = 1; m1_rready = 1;
        settle();
        chk("cont_g1_addr",  s_araddr,        32'h100);
        chk("cont_g1_m0",    32'(m0_arready), 1);
        chk("cont_g1_m1",    32'(m1_arready), 0);
        tick();
        s_rvalid = 1; s_rdata = 32'hA0;
        settle();
        chk("cont_g2_addr",  s_araddr,        32'h200);
        chk("cont_g2_prot",  32'(s_arprot),   32'h1);
        chk("cont_g2_m1",    32'(m1_arready), 1);
        chk("cont_g2_m0",    32'(m0_arready), 0);
        chk("cont_r1_m0",    32'(m0_rvalid),  1);
        chk("cont_r1_m1",    32'(m1_rvalid),  0);
        tick();
        s_rdata = 32'hA1;
        settle();
        chk("cont_g3_addr",  s_araddr,        32'h100);
        chk("cont_g3_m0",    32'(m0_arready), 1);
        chk("cont_r2_m1",    32'(m1_rvalid),  1);
        chk("cont_r2_m0",    32'(m0_rvalid),  0);
        chk("cont_r2_data",  m1_rdata,        32'hA1);
        tick();
        s_rdata = 32'hA2;
        settle();
        chk("cont_g4_addr",  s_araddr,        32'h200);
        chk("cont_g4_m1",    32'(m1_arready), 1);
        chk("cont_r3_m0",    32'(m0_rvalid),  1);
        tick();
        m0_arvalid = 0; m1_arvalid = 0; s_rdata = 32'hA3;
        settle();
        chk("cont_r4_m1",    32'(m1_rvalid),  1);
        chk("cont_r4_m0",    32'(m0_rvalid),  0);
        tick();
        s_rvalid = 0;
        settle();
        chk("cont_cnt_end",  32'(dut.count),  0);

        // ---- lock: m1 granted, slave stalls 3 cycles, m0 requests meanwhile
        m1_arvalid = 1; s_arready = 0;
        settle();
        chk("lock_c1_valid", 32'(s_arvalid),  1);
        chk("lock_c1_addr",  s_araddr,        32'h200);
        chk("lock_c1_m1",    32'(m1_arready), 0);
        tick();
        m0_arvalid = 1;
        settle();
        chk("lock_c2_addr",  s_araddr,        32'h200);
        chk("lock_c2_m0",    32'(m0_arready), 0);
        tick();
        settle();
        chk("lock_c3_addr",  s_araddr,        32'h200);
        chk("lock_c3_valid", 32'(s_arvalid),  1);
        tick();
        s_arready = 1;
        settle();
        chk("lock_hs_addr",  s_araddr,        32'h200);
        chk("lock_hs_m1",    32'(m1_arready), 1);
        chk("lock_hs_m0",    32'(m0_arready), 0);
        tick();
        m1_arvalid = 0;
        settle();
        chk("lock_next_m0",  32'(m0_arready), 1);
        chk("lock_next_addr", s_araddr,       32'h100);
        tick();

        // ---- full: two outstanding (m1, m0), slave withholds rvalid
        m1_arvalid = 1;
        settle();
        chk("full_cnt",      32'(dut.count),  2);
        chk("full_arvalid",  32'(s_arvalid),  0);
        chk("full_m0",       32'(m0_arready), 0);
        chk("full_m1",       32'(m1_arready), 0);
        s_rvalid = 1; s_rdata = 32'hB0;
        settle();
        chk("full_pop_arv",  32'(s_arvalid),  0);
        chk("full_pop_m1rv", 32'(m1_rvalid),  1);
        tick();
        s_rvalid = 0;
        settle();
        chk("full_after_arv", 32'(s_arvalid), 1);
        chk("full_after_m1", 32'(m1_arready), 1);
        chk("full_after_m0", 32'(m0_arready), 0);
        tick();
        m0_arvalid = 0; m1_arvalid = 0;

        // ---- backpressure + error: head is m0, m0 not ready for 2 cycles
        s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h55; m0_rready = 0;
        settle();
        chk("bp_c1_srdy",    32'(s_rready),   0);
        chk("bp_c1_m0rv",    32'(m0_rvalid),  1);
        chk("bp_c1_m1rv",    32'(m1_rvalid),  0);
        tick();
        settle();
        chk("bp_c2_srdy",    32'(s_rready),   0);
        chk("bp_c2_m1rv",    32'(m1_rvalid),  0);
        tick();
        m0_rready = 1;
        settle();
        chk("bp_go_srdy",    32'(s_rready),   1);
        chk("bp_go_resp",    32'(m0_rresp),   32'h2);
        chk("bp_go_m1rv",    32'(m1_rvalid),  0);
        tick();
        s_rvalid = 0; s_rresp = 2'b00;
        settle();
        chk("bp_cnt",        32'(dut.count),  1);

        // ---- reset mid-flight with one read (owner m1) outstanding
        s_rvalid = 1; m0_arvalid = 1; s_arready = 1;
        settle();
        chk("rst_pre_m1rv",  32'(m1_rvalid),  1);
        reset = 1;
        settle();
        chk_all_zero("rst_mid");
        tick();
        s_rvalid = 0;
        m1_arvalid = 1;
        #2;
        reset = 0;
        settle();
        chk("rst_post_m0",   32'(m0_arready), 1);
        chk("rst_post_m1",   32'(m1_arready), 0);
        chk("rst_post_addr", s_araddr,        32'h100);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter sharing one instruction/data memory read port between the IF stage fetch interface (master 0) and the load/store unit (master 1). It arbitrates read-address requests round-robin and records the owner of each accepted request in an in-order ID FIFO. It routes each read response back to its owner. AR and R paths are combinational pass-throughs, adding no latency; the only state is the grant lock, the round-robin pointer and the ID FIFO.

## Interface
- MAX_OUTST, default 2: maximum outstanding reads accepted by the slave. ID FIFO depth; must be ≥1.
- ADDR_WIDTH, default 32: read address width.
- DATA_WIDTH, default 32: read data width.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- m0_araddr / m1_araddr  in  ADDR_WIDTH  master read address.
- m0_arprot / m1_arprot  in  3  master protection bits.
- m0_arvalid / m1_arvalid  in  1  master address valid.
- m0_arready / m1_arready  out  1  address accepted.
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data (both driven from s_rdata).
- m0_rresp / m1_rresp  out  2  response (both driven from s_rresp).
- m0_rvalid / m1_rvalid  out  1  response valid, owner only.
- m0_rready / m1_rready  in  1  master ready for response.
- s_araddr  out  ADDR_WIDTH  slave read address.
- s_arprot  out  3  slave protection bits.
- s_arvalid  out  1  slave address valid.
- s_arready  in  1  slave address ready.
- s_rdata  in  DATA_WIDTH  slave read data.
- s_rresp  in  2  slave response.
- s_rvalid  in  1  slave response valid.
- s_rready  out  1  slave response ready.

## Operation
- State:
  - lock, 1 bit.
  - lock_id, 1 bit.
  - rr_prio, 1 bit: favoured master.
  - ID FIFO of MAX_OUTST 1-bit entries, with rd/wr pointers and a count of width clog2(MAX_OUTST+1).
- Grant selection, combinational:
  - If lock, grant = lock_id.
  - Else if exactly one m*_arvalid, grant that master.
  - Else if both are valid, grant rr_prio.
  - Else no grant.
- AR path:
  - s_arvalid = granted m_arvalid && !full.
  - s_araddr / s_arprot = granted master's fields. When there is no grant, they are master 0's fields.
  - Granted master's arready = s_arready && !full. The non-granted master's arready = 0.
- AR handshake, s_arvalid && s_arready:
  - Push grant ID into the FIFO.
  - rr_prio <= ~grant.
  - lock <= 0.
- Lock:
  - If s_arvalid && !s_arready, then lock <= 1 and lock_id <= grant.
  - This keeps the slave-visible address stable per AXI until handshake.
  - The lock is not set while full, because s_arvalid is 0.
- R path:
  - head = FIFO[rd_ptr].
  - When FIFO is non-empty: m{head}_rvalid = s_rvalid, and s_rready = m{head}_rready.
  - When FIFO is empty: s_rready = 0 and both m*_rvalid = 0. An s_rvalid while empty is ignored (protocol violation).
- R handshake, s_rvalid && s_rready: pop the FIFO.
- rresp is passed through unchanged; errors are handled by the masters.
- Full: count == MAX_OUTST. New AR is blocked even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Pointers wrap modulo MAX_OUTST.
- Reset values:
  - lock = 0, lock_id = 0, rr_prio = 0 (master 0 favoured), FIFO empty.
  - All outputs 0: *_arready, s_arvalid, *_rvalid, s_rready.
- Reset mid-operation: the FIFO and lock are cleared asynchronously. In-flight responses are discarded; the slave is reset on the same signal.

## Timing
- AR and R are zero-latency combinational paths. There is no register in the address or data path.
- The FIFO push is visible on the next cycle. A response may be accepted in the cycle after its AR handshake, at the earliest.
- The lock and rr_prio update on the clock edge following the AR event.
- No combinational path from s_rvalid to any arready.

## Test plan
- Solo fetch:
  - Stimulus: m0 issues 0x0000_0000 then 0x0000_0004 back-to-back. Slave accepts each immediately and returns data 1 cycle later.
  - Required: m0 sees two rvalids in order. m1_rvalid stays 0. FIFO count peaks at 2.
- Contention:
  - Stimulus: m0 and m1 both hold arvalid for 4 consecutive handshakes.
  - Required: grants alternate m0, m1, m0, m1, starting from m0 after reset. Responses are routed in the same order.
- Lock:
  - Stimulus: m1 is granted; slave holds s_arready = 0 for 3 cycles while m0 raises arvalid.
  - Required: s_araddr stays at m1's address and the grant stays m1 until handshake. m0 is granted on the next cycle.
- Full:
  - Stimulus: MAX_OUTST = 2, two reads outstanding, slave withholds rvalid.
  - Required: s_arvalid = 0 and both arready = 0. After one R handshake, the next cycle permits a new AR.
- Backpressure and error:
  - Stimulus: the head owner is m0 with m0_rready = 0 for 2 cycles, and s_rresp = 2'b10.
  - Required: s_rready = 0 for those cycles. m0 receives rresp 2'b10 when ready. m1 never sees rvalid.
- Reset mid-flight:
  - Stimulus: assert reset with 1 read outstanding.
  - Required: all outputs are 0 immediately and the FIFO is empty. After release, the first grant goes to m0.
